// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order word reads, buffers {instr, pc} and hands them to decode.
// Optional IFETCH_MISALIGN_CHK_EN adds a sticky fetch_misaligned flag for unaligned redirect targets.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcplus4
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam ptr_t        PTR_ONE = ptr_t'(1);
    localparam cnt_t        CNT_ONE = cnt_t'(1);

    logic [31:0] pc_q;
    logic [31:0] buf_instr [FIFO_DEPTH];
    logic [31:0] buf_pc    [FIFO_DEPTH];
    logic [31:0] tag_q     [FIFO_DEPTH];
    ptr_t        buf_rd, buf_wr, tag_rd, tag_wr;
    cnt_t        count, outstanding, drop_cnt;

    logic        credit_ok;
    logic        req_fire;
    logic        rsp_keep;
    logic        rsp_drop;
    logic        pop;

    // Credits cover both buffered words and words still in flight, so responses never need backpressure.
    assign credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
    assign imem_req_valid = !reset && !redirect && (drop_cnt == '0) && credit_ok;
    assign imem_addr      = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect;
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign pop      = id_valid && id_ready && !redirect;

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            buf_rd      <= '0;
            buf_wr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // Everything still in flight belongs to the old path and is discarded on return.
            pc_q        <= {redirect_pc[31:2], 2'b00};
            buf_rd      <= '0;
            buf_wr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= outstanding - cnt_t'(imem_rsp_valid);
            drop_cnt    <= outstanding - cnt_t'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_q   <= pc_q + 32'd4;
                tag_wr <= tag_wr + PTR_ONE;
            end
            if (rsp_keep) begin
                buf_wr <= buf_wr + PTR_ONE;
                tag_rd <= tag_rd + PTR_ONE;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_ONE;
            end
            if (pop) begin
                buf_rd <= buf_rd + PTR_ONE;
            end
            outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
            count       <= count + cnt_t'(rsp_keep) - cnt_t'(pop);
        end
    end

    // NOTE: the buffer and tag storage carry no reset; validity is tracked solely by the
    // reset counters and pointers, which keeps the arrays plain RAM-style storage.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr] <= pc_q;
        end
        if (rsp_keep) begin
            buf_instr[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]    <= tag_q[tag_rd];
        end
    end

    // NOTE: every output driven from always_comb is given a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        id_valid   = 1'b0;
        id_instr   = NOP;
        id_pc      = pc_q;
        if (count != '0) begin
            id_valid = 1'b1;
            id_instr = buf_instr[buf_rd];
            id_pc    = buf_pc[buf_rd];
        end
        id_pcplus4 = id_pc + 32'd4;
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_misaligned <= 1'b0;
        end else if (redirect) begin
            fetch_misaligned <= |redirect_pc[1:0];
        end
    end
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    // A response with nothing outstanding means the memory broke the in-order contract.
    a_no_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outstanding != '0))
        else $error("instr_fetch: response with no outstanding request");

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, outstanding} + {1'b0, count}) <= DEPTH_W)
        else $error("instr_fetch: credit bound exceeded");

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: PC-stream reference model, random memory timing,
// redirects, reset mid-stream, and a second instance exercising PC wrap-around.
module tb_instr_fetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC_A = 32'h0000_0000;
    localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_pcplus4;

    logic        req_valid_b, rsp_valid_b, id_valid_b;
    logic [31:0] addr_b, rsp_data_b, id_instr_b, id_pc_b, id_pcplus4_b;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        fetch_misaligned, fetch_misaligned_b;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC_A), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pcplus4(id_pcplus4)
`ifdef IFETCH_MISALIGN_CHK_EN
        , .fetch_misaligned(fetch_misaligned)
`endif
    );

    instr_fetch #(.RESET_PC(RST_PC_B), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid_b), .imem_req_ready(1'b1), .imem_addr(addr_b),
        .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
        .redirect(1'b0), .redirect_pc(32'h0),
        .id_valid(id_valid_b), .id_ready(1'b1), .id_instr(id_instr_b),
        .id_pc(id_pc_b), .id_pcplus4(id_pcplus4_b)
`ifdef IFETCH_MISALIGN_CHK_EN
        , .fetch_misaligned(fetch_misaligned_b)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC3A5_0F01;
    endfunction

    // Fixed one-cycle memory for the wrap-around instance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_b <= 1'b0;
            rsp_data_b  <= 32'h0;
        end else begin
            rsp_valid_b <= req_valid_b;
            rsp_data_b  <= mem_word(addr_b);
        end
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_fires = 0;
    int          consumed = 0;
    int          first_valid_cyc = -1;
    int          wrap_n = 0;
    logic [31:0] fetch_pc, exp_pc, prev_addr, first_after;
    bit          hold_prev, post_redir, await_first, mis_exp;
    logic [31:0] wrap_tbl [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample and compare at the falling edge.
    task automatic step(input bit rdy, input bit idr, input bit redir,
                        input logic [31:0] rpc, input int lat);
        bit          rsp_fire;
        logic [31:0] rpc_al;
        rpc_al         = {rpc[31:2], 2'b00};
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect       = redir;
        redirect_pc    = rpc;
        rsp_fire       = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            rsp_fire       = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        if (redir) check("req_blocked_on_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
        if (hold_prev && !redir) check("addr_stable", imem_addr, prev_addr);
        if (imem_req_valid && rdy) begin
            check("req_addr", imem_addr, fetch_pc);
            pend.push_back('{addr: imem_addr, due: cyc + lat});
            fetch_pc  = fetch_pc + 32'd4;
            req_fires++;
        end
        hold_prev = imem_req_valid && !rdy;
        prev_addr = imem_addr;
        if (rsp_fire) void'(pend.pop_front());
        if (post_redir) check("id_valid_after_redirect", 32'(id_valid), 32'd0);
        if (!id_valid) check("nop_when_empty", id_instr, NOP);
        if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (id_valid && idr && !redir) begin
            check("id_pc", id_pc, exp_pc);
            check("id_instr", id_instr, mem_word(exp_pc));
            check("id_pcplus4", id_pcplus4, exp_pc + 32'd4);
            if (await_first) begin
                first_after = id_pc;
                await_first = 1'b0;
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
`ifdef IFETCH_MISALIGN_CHK_EN
        check("fetch_misaligned", 32'(fetch_misaligned), 32'(mis_exp));
`endif
        if (redir) begin
            fetch_pc    = rpc_al;
            exp_pc      = rpc_al;
            await_first = 1'b1;
            mis_exp     = (rpc[1:0] != 2'b00);
        end
        post_redir = redir;
        if (id_valid_b && wrap_n < 3) begin
            check("wrap_id_pc", id_pc_b, wrap_tbl[wrap_n]);
            check("wrap_id_instr", id_instr_b, mem_word(wrap_tbl[wrap_n]));
            check("wrap_id_pcplus4", id_pcplus4_b, wrap_tbl[wrap_n] + 32'd4);
            wrap_n++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called just after a rising edge; reset is asserted asynchronously mid-cycle.
    task automatic do_reset();
        #2;
        reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        #1;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_pc", id_pc, RST_PC_A);
        check("rst_wrap_id_pc", id_pc_b, RST_PC_B);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
        pend.delete();
        fetch_pc        = RST_PC_A;
        exp_pc          = RST_PC_A;
        hold_prev       = 1'b0;
        post_redir      = 1'b0;
        await_first     = 1'b0;
        mis_exp         = 1'b0;
        wrap_n          = 0;
        first_valid_cyc = -1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start_fires;
        bit have_hold;
        logic [31:0] hold_pc, hold_instr;

        wrap_tbl[0] = 32'hFFFF_FFF8;
        wrap_tbl[1] = 32'hFFFF_FFFC;
        wrap_tbl[2] = 32'h0000_0000;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Streaming from reset: first decode entry two cycles after the first request.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("first_id_valid_cycle", 32'(first_valid_cyc), 32'd2);
        check("wrap_entries_seen", 32'(wrap_n), 32'd3);

        // Decode stall: credits allow exactly DEPTH requests, head entry held.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        start_fires = req_fires;
        have_hold   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1);
            if (id_valid && !have_hold) begin
                have_hold  = 1'b1;
                hold_pc    = id_pc;
                hold_instr = id_instr;
            end else if (have_hold) begin
                check("stall_hold_pc", id_pc, hold_pc);
                check("stall_hold_instr", id_instr, hold_instr);
            end
        end
        check("stall_req_count", 32'(req_fires - start_fires), 32'(DEPTH));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Redirect with two fetches in flight.
        for (int i = 0; i < 20; i++) begin
            if (pend.size() == 2) break;
            step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        end
        first_after = 32'hDEAD_BEEF;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 3);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        check("first_pc_after_redirect", first_after, 32'h0000_0100);

`ifdef IFETCH_MISALIGN_CHK_EN
        first_after = 32'hDEAD_BEEF;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1);
        check("misaligned_set", 32'(fetch_misaligned), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("misaligned_first_pc", first_after, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1);
        check("misaligned_cleared", 32'(fetch_misaligned), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
`endif

        // Random memory timing, decode stalls and redirects, with a reset mid-stream.
        for (int i = 0; i < 700; i++) begin
            if (i == 350) do_reset();
            step(($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
                 $urandom, 1 + int'($urandom % 5));
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("consumed_nonzero", 32'(consumed > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
